axi4_sram_responder: RTL and testbench

AXI4 slave-side responder that terminates the same single-ID, 64-bit AXI4 write/read channels the DDR2 controller exposes, backed by an on-chip word array. Used as the golden memory model behind bus masters and directed tests, and as a drop-in stand-in for the DDR2 controller during bring-up. Write and read paths are independent FSMs sharing one storage array.

---
 rtl/axi4_sram_responder.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_axi4_sram_responder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_responder.sv
// -----------------------------------------------------------------------------
// axi4_sram_responder
//
// AXI4 slave responder for a single-ID, 64-bit bus. It is backed by an on-chip
// word array. The write and read paths are independent FSMs that share one
// storage array. It serves as a golden memory model and as a bring-up stand-in
// for the DDR2 controller.
//
// Parameters
//   DATA_WIDTH : data bus width (only 64 is supported)
//   ADDR_WIDTH : byte address width
//   MEM_DEPTH  : storage depth in 64-bit words (power of two)
//
// Ports
//   clk, rst                        : clock, asynchronous active-high reset
//   axi_aw* (addr/len/size/burst)   : write address channel, valid/ready
//   axi_w*  (data/strb/last)        : write data channel, valid/ready
//   axi_b*  (resp)                  : write response channel, valid/ready
//   axi_ar* (addr/len/size/burst)   : read address channel, valid/ready
//   axi_r*  (data/resp/last)        : read data channel, valid/ready
//
// Word index = addr[3 +: log2(MEM_DEPTH)]. Upper address bits alias, and the
// byte offset is ignored. Only 64-bit beats with FIXED or INCR bursts are
// legal. Any other burst is accepted but answered with SLVERR: bad writes
// commit nothing, and bad reads return zero data.
// -----------------------------------------------------------------------------
module axi4_sram_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic                    axi_rvalid,
  input  logic                    axi_rready
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  localparam logic [IDX_W-1:0]      IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // A burst is legal only with full-width beats and a FIXED or INCR type.
  function automatic logic burst_is_bad(input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = (size == SIZE_8B) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
    return !ok;
  endfunction

  // An INCR burst advances one word per beat and wraps modulo the array
  // depth (natural index overflow). A FIXED burst keeps its index.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                  input logic             fixed);
    logic [IDX_W-1:0] nxt;
    if (fixed) begin
      nxt = idx;
    end else begin
      nxt = idx + IDX_ONE;
    end
    return nxt;
  endfunction

  // Storage array. It is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // Write path state
  w_state_t         w_state_r, w_state_next_s;
  logic [IDX_W-1:0] w_idx_r;
  logic [7:0]       w_len_r;
  logic [7:0]       w_cnt_r;
  logic             w_bad_r;
  logic             w_err_r;
  logic             w_fixed_r;
  logic             aw_fire_s;
  logic             w_fire_s;
  logic             w_last_beat_s;
  logic             w_wlast_bad_s;
  logic             b_fire_s;

  // Read path state
  r_state_t         r_state_r, r_state_next_s;
  logic [IDX_W-1:0] r_idx_r;
  logic [7:0]       r_len_r;
  logic [7:0]       r_cnt_r;
  logic             r_bad_r;
  logic             r_fixed_r;
  logic             ar_fire_s;
  logic             r_fire_s;
  logic             r_load_s;
  logic [IDX_W-1:0] r_rd_idx_s;
  logic             r_rd_bad_s;

  // The byte offset and aliased upper address bits carry no information here.
  logic unused_s;
  assign unused_s = ^{axi_awaddr[2:0], axi_awaddr[ADDR_WIDTH-1:3+IDX_W],
                      axi_araddr[2:0], axi_araddr[ADDR_WIDTH-1:3+IDX_W]};

  // Write FSM: next-state and handshake decode
  always_comb begin
    w_state_next_s = w_state_r;
    aw_fire_s      = 1'b0;
    w_fire_s       = 1'b0;
    w_last_beat_s  = (w_cnt_r == w_len_r);
    w_wlast_bad_s  = 1'b0;
    b_fire_s       = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (axi_awvalid && axi_awready) begin
          aw_fire_s      = 1'b1;
          w_state_next_s = W_DATA;
        end else begin
          w_state_next_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (axi_wvalid && axi_wready) begin
          w_fire_s = 1'b1;
          // wlast must line up exactly with beat awlen. A misplaced wlast only
          // flags an error; the beat count alone decides where the burst ends.
          w_wlast_bad_s = (axi_wlast != w_last_beat_s);
          if (w_last_beat_s) begin
            w_state_next_s = W_RESP;
          end else begin
            w_state_next_s = W_DATA;
          end
        end else begin
          w_state_next_s = W_DATA;
        end
      end
      W_RESP: begin
        if (axi_bvalid && axi_bready) begin
          b_fire_s       = 1'b1;
          w_state_next_s = W_IDLE;
        end else begin
          w_state_next_s = W_RESP;
        end
      end
      default: begin
        w_state_next_s = W_IDLE;
      end
    endcase
  end

  // Write FSM: state, burst context and registered channel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_r   <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      w_idx_r     <= IDX_ZERO;
      w_len_r     <= 8'd0;
      w_cnt_r     <= 8'd0;
      w_bad_r     <= 1'b0;
      w_err_r     <= 1'b0;
      w_fixed_r   <= 1'b0;
    end else begin
      w_state_r   <= w_state_next_s;
      axi_awready <= (w_state_next_s == W_IDLE);
      axi_wready  <= (w_state_next_s == W_DATA);
      axi_bvalid  <= (w_state_next_s == W_RESP);
      if (aw_fire_s) begin
        w_idx_r   <= axi_awaddr[3 +: IDX_W];
        w_len_r   <= axi_awlen;
        w_cnt_r   <= 8'd0;
        w_bad_r   <= burst_is_bad(axi_awsize, axi_awburst);
        w_err_r   <= 1'b0;
        w_fixed_r <= (axi_awburst == BURST_FIXED);
      end else if (w_fire_s) begin
        w_cnt_r <= w_cnt_r + 8'd1;
        w_idx_r <= next_index(w_idx_r, w_fixed_r);
        w_err_r <= w_err_r | w_wlast_bad_s;
        // The final beat's own wlast check is folded in directly, because
        // w_err_r only updates on this same edge.
        if (w_last_beat_s) begin
          axi_bresp <= (w_bad_r || w_err_r || w_wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
        end
      end else if (b_fire_s) begin
        axi_bresp <= RESP_OKAY;
      end
    end
  end

  // Byte-enabled write port. Beats of an illegal burst are dropped.
  always_ff @(posedge clk) begin
    if (w_fire_s && !w_bad_r) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_wstrb[b]) begin
          mem_r[w_idx_r][8*b +: 8] <= axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read FSM: next-state, handshake decode and index of the next word to fetch
  always_comb begin
    r_state_next_s = r_state_r;
    ar_fire_s      = 1'b0;
    r_fire_s       = 1'b0;
    r_rd_idx_s     = r_idx_r;
    r_rd_bad_s     = r_bad_r;
    case (r_state_r)
      R_IDLE: begin
        if (axi_arvalid && axi_arready) begin
          ar_fire_s      = 1'b1;
          r_rd_idx_s     = axi_araddr[3 +: IDX_W];
          r_rd_bad_s     = burst_is_bad(axi_arsize, axi_arburst);
          r_state_next_s = R_DATA;
        end else begin
          r_state_next_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (axi_rvalid && axi_rready) begin
          r_fire_s = 1'b1;
          if (axi_rlast) begin
            r_state_next_s = R_IDLE;
          end else begin
            r_rd_idx_s     = next_index(r_idx_r, r_fixed_r);
            r_state_next_s = R_DATA;
          end
        end else begin
          r_state_next_s = R_DATA;
        end
      end
      default: begin
        r_state_next_s = R_IDLE;
      end
    endcase
    // Fetch on address acceptance and on every accepted beat except the last.
    r_load_s = ar_fire_s || (r_fire_s && !axi_rlast);
  end

  // Read FSM: state, burst context and registered R channel. R outputs change
  // only on a handshake, so they hold stable while rready is low. A read that
  // collides with a write returns the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_r   <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rresp   <= RESP_OKAY;
      axi_rdata   <= DATA_ZERO;
      r_idx_r     <= IDX_ZERO;
      r_len_r     <= 8'd0;
      r_cnt_r     <= 8'd0;
      r_bad_r     <= 1'b0;
      r_fixed_r   <= 1'b0;
    end else begin
      r_state_r   <= r_state_next_s;
      axi_arready <= (r_state_next_s == R_IDLE);
      axi_rvalid  <= (r_state_next_s == R_DATA);
      if (ar_fire_s) begin
        r_idx_r   <= r_rd_idx_s;
        r_len_r   <= axi_arlen;
        r_cnt_r   <= 8'd0;
        r_bad_r   <= r_rd_bad_s;
        r_fixed_r <= (axi_arburst == BURST_FIXED);
        axi_rlast <= (axi_arlen == 8'd0);
      end else if (r_fire_s && !axi_rlast) begin
        r_idx_r   <= r_rd_idx_s;
        r_cnt_r   <= r_cnt_r + 8'd1;
        axi_rlast <= ((r_cnt_r + 8'd1) == r_len_r);
      end else if (r_fire_s) begin
        axi_rlast <= 1'b0;
      end
      if (r_load_s) begin
        axi_rdata <= r_rd_bad_s ? DATA_ZERO : mem_r[r_rd_idx_s];
        axi_rresp <= r_rd_bad_s ? RESP_SLVERR : RESP_OKAY;
      end else if (r_fire_s) begin
        axi_rdata <= DATA_ZERO;
        axi_rresp <= RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi4_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_axi4_sram_responder
//
// Directed self-checking bench for axi4_sram_responder. Each scenario task
// drives bursts through the stimulus tasks do_write/do_read and compares the
// observed results against hand-computed values. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi4_sram_responder;

  logic        clk;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  int n_checks = 0;
  int n_pass   = 0;

  // Write beat table and results of the latest write burst
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [1:0]  wr_resp;
  int          wr_beats;
  int          wr_bwait;
  logic        wr_first_ready;
  logic        wr_ok;

  // Captured beats and results of the latest read burst
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_n;
  int          rd_gap;
  logic        rd_hold_ok;
  logic        rd_ok;

  axi4_sram_responder dut (
    .clk         (clk),
    .rst         (rst),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full write burst: AW, then len+1 W beats from wd/ws, then B.
  // wlast is driven on beat wlast_at (-1 = never).
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int wlast_at);
    int cyc;
    wr_ok = 1'b1; wr_beats = 0; wr_bwait = 0; cyc = 0;
    @(negedge clk);
    axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    while (axi_awready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (axi_awready !== 1'b1) wr_ok = 1'b0;
    @(negedge clk);
    axi_awvalid = 1'b0;
    wr_first_ready = axi_wready;
    while (wr_beats <= int'(len) && cyc < 200) begin
      axi_wdata  = wd[wr_beats];
      axi_wstrb  = ws[wr_beats];
      axi_wlast  = (wr_beats == wlast_at);
      axi_wvalid = 1'b1;
      if (axi_wready === 1'b1) wr_beats++;
      @(negedge clk); cyc++;
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    if (wr_beats <= int'(len)) wr_ok = 1'b0;
    axi_bready = 1'b1;
    while (axi_bvalid !== 1'b1 && cyc < 250) begin @(negedge clk); cyc++; wr_bwait++; end
    if (axi_bvalid !== 1'b1) wr_ok = 1'b0;
    wr_resp = axi_bresp;
    @(negedge clk);
    axi_bready = 1'b0;
  endtask

  // Full read burst. After beat stall_after is accepted, rready drops for
  // stall_cycles cycles while the presented beat is watched for stability.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_after, input int stall_cycles);
    int          cyc;
    int          stall_left;
    logic        done;
    logic [63:0] hd;
    logic        hl;
    rd_ok = 1'b1; rd_n = 0; rd_gap = 0; rd_hold_ok = 1'b1;
    cyc = 0; stall_left = 0; done = 1'b0; hd = 64'd0; hl = 1'b0;
    @(negedge clk);
    axi_araddr = addr; axi_arlen = len; axi_arsize = size; axi_arburst = burst;
    axi_arvalid = 1'b1;
    while (axi_arready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (axi_arready !== 1'b1) rd_ok = 1'b0;
    @(negedge clk);
    axi_arvalid = 1'b0;
    while (!done && cyc < 200) begin
      if (stall_left > 0) begin
        axi_rready = 1'b0;
        if (stall_left == stall_cycles) begin
          hd = axi_rdata; hl = axi_rlast;
        end else if (axi_rdata !== hd || axi_rlast !== hl) begin
          rd_hold_ok = 1'b0;
        end
        if (axi_rvalid !== 1'b1) rd_hold_ok = 1'b0;
        stall_left--;
      end else begin
        axi_rready = 1'b1;
      end
      if (axi_rvalid === 1'b1 && axi_rready === 1'b1) begin
        if (rd_n < 16) begin
          rd_data[rd_n] = axi_rdata;
          rd_resp[rd_n] = axi_rresp;
          rd_last[rd_n] = axi_rlast;
        end
        if (rd_n == stall_after) stall_left = stall_cycles;
        done = (axi_rlast === 1'b1);
        rd_n++;
      end else if (axi_rready === 1'b1) begin
        rd_gap++;
      end
      @(negedge clk); cyc++;
    end
    if (!done) rd_ok = 1'b0;
    axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    axi_awaddr = 32'd0; axi_awlen = 8'd0; axi_awsize = 3'd0; axi_awburst = 2'd0;
    axi_awvalid = 1'b0; axi_wdata = 64'd0; axi_wstrb = 8'd0; axi_wlast = 1'b0;
    axi_wvalid = 1'b0; axi_bready = 1'b0; axi_araddr = 32'd0; axi_arlen = 8'd0;
    axi_arsize = 3'd0; axi_arburst = 2'd0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready, axi_rvalid, axi_rlast, axi_rresp} !== 10'd0)
      $display("FAIL reset_ctrl: got %b want %b",
               {axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready, axi_rvalid, axi_rlast, axi_rresp}, 10'd0);
    else n_pass++;
    n_checks++;
    if (axi_rdata !== 64'd0) $display("FAIL reset_rdata: got %h want %h", axi_rdata, 64'd0);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({axi_awready, axi_arready} !== 2'b00)
      $display("FAIL reset_ready_before_edge: got %b want %b", {axi_awready, axi_arready}, 2'b00);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({axi_awready, axi_arready, axi_wready, axi_rvalid} !== 4'b1100)
      $display("FAIL reset_ready_after_edge: got %b want %b",
               {axi_awready, axi_arready, axi_wready, axi_rvalid}, 4'b1100);
    else n_pass++;
  endtask

  task automatic test_single();
    wd[0] = 64'hDEADBEEFCAFEBABE; ws[0] = 8'hFF;
    do_write(32'h0000_1000, 8'd0, 3'b011, 2'b01, 0);
    n_checks++;
    if (wr_ok !== 1'b1 || wr_first_ready !== 1'b1 || wr_bwait != 0)
      $display("FAIL single_w_timing: got ok=%b wready=%b bwait=%0d want 1 1 0", wr_ok, wr_first_ready, wr_bwait);
    else n_pass++;
    n_checks++;
    if (wr_resp !== 2'b00) $display("FAIL single_bresp: got %b want %b", wr_resp, 2'b00);
    else n_pass++;
    n_checks++;
    if (axi_awready !== 1'b1) $display("FAIL single_awready_after_b: got %b want 1", axi_awready);
    else n_pass++;
    do_read(32'h0000_1000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_ok !== 1'b1 || rd_n != 1 || rd_gap != 0)
      $display("FAIL single_r_timing: got ok=%b beats=%0d gap=%0d want 1 1 0", rd_ok, rd_n, rd_gap);
    else n_pass++;
    n_checks++;
    if (rd_data[0] !== 64'hDEADBEEFCAFEBABE || rd_resp[0] !== 2'b00 || rd_last[0] !== 1'b1)
      $display("FAIL single_rbeat: got %h/%b/%b want deadbeefcafebabe/00/1", rd_data[0], rd_resp[0], rd_last[0]);
    else n_pass++;
    n_checks++;
    if ({axi_arready, axi_rvalid} !== 2'b10)
      $display("FAIL single_after_r: got %b want %b", {axi_arready, axi_rvalid}, 2'b10);
    else n_pass++;
  endtask

  task automatic test_incr();
    logic [63:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'h1111111111111111 + 64'(i); ws[i] = 8'hFF;
    end
    do_write(32'h0000_2000, 8'd3, 3'b011, 2'b01, 3);
    n_checks++;
    if (wr_ok !== 1'b1 || wr_beats != 4 || wr_resp !== 2'b00)
      $display("FAIL incr_write: got ok=%b beats=%0d resp=%b want 1 4 00", wr_ok, wr_beats, wr_resp);
    else n_pass++;
    do_read(32'h0000_2000, 8'd3, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_ok !== 1'b1 || rd_n != 4 || rd_gap != 0)
      $display("FAIL incr_r_count: got ok=%b beats=%0d gap=%0d want 1 4 0", rd_ok, rd_n, rd_gap);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_d = 64'h1111111111111111 + 64'(i);
      n_checks++;
      if (rd_data[i] !== exp_d || rd_last[i] !== (i == 3))
        $display("FAIL incr_beat%0d: got %h last=%b want %h last=%b", i, rd_data[i], rd_last[i], exp_d, (i == 3));
      else n_pass++;
    end
    wd[0] = 64'hAAAAAAAAAAAAAAAA; ws[0] = 8'hFF;
    do_write(32'h0001_0000, 8'd0, 3'b011, 2'b01, 0);
    wd[0] = 64'h5555555555555555;
    do_write(32'h0002_0000, 8'd0, 3'b011, 2'b01, 0);
    do_read(32'h0001_0000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_data[0] !== 64'hAAAAAAAAAAAAAAAA) $display("FAIL addr_10000: got %h want aaaaaaaaaaaaaaaa", rd_data[0]);
    else n_pass++;
    do_read(32'h0002_0000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_data[0] !== 64'h5555555555555555) $display("FAIL addr_20000: got %h want 5555555555555555", rd_data[0]);
    else n_pass++;
  endtask

  task automatic test_wrap_alias_fixed();
    // INCR from the last word wraps to word 0, and bit 19 aliases onto word 0.
    wd[0] = 64'h0123456789ABCDEF; wd[1] = 64'hFEDCBA9876543210; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(32'h0007_FFF8, 8'd1, 3'b011, 2'b01, 1);
    do_read(32'h0000_0000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_data[0] !== 64'hFEDCBA9876543210) $display("FAIL wrap_word0: got %h want fedcba9876543210", rd_data[0]);
    else n_pass++;
    do_read(32'h0008_0000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_data[0] !== 64'hFEDCBA9876543210) $display("FAIL alias_word0: got %h want fedcba9876543210", rd_data[0]);
    else n_pass++;
    // FIXED burst: both beats land on the same word, so the second one wins.
    wd[0] = 64'hA0A0A0A0A0A0A0A0; wd[1] = 64'hB0B0B0B0B0B0B0B0;
    do_write(32'h0000_5000, 8'd1, 3'b011, 2'b00, 1);
    do_read(32'h0000_5000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_data[0] !== 64'hB0B0B0B0B0B0B0B0) $display("FAIL fixed_write: got %h want b0b0b0b0b0b0b0b0", rd_data[0]);
    else n_pass++;
  endtask

  task automatic test_strobe();
    wd[0] = 64'hFFFFFFFFFFFFFFFF; ws[0] = 8'hFF;
    do_write(32'h0000_3000, 8'd0, 3'b011, 2'b01, 0);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    do_write(32'h0000_3000, 8'd0, 3'b011, 2'b01, 0);
    do_read(32'h0000_3000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_data[0] !== 64'hFFFFFFFF00000000) $display("FAIL strobe: got %h want ffffffff00000000", rd_data[0]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_d;
    do_read(32'h0000_2000, 8'd3, 3'b011, 2'b01, 1, 3);
    n_checks++;
    if (rd_ok !== 1'b1 || rd_n != 4 || rd_hold_ok !== 1'b1)
      $display("FAIL stall_count_hold: got ok=%b beats=%0d hold=%b want 1 4 1", rd_ok, rd_n, rd_hold_ok);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_d = 64'h1111111111111111 + 64'(i);
      n_checks++;
      if (rd_data[i] !== exp_d || rd_last[i] !== (i == 3))
        $display("FAIL stall_beat%0d: got %h last=%b want %h last=%b", i, rd_data[i], rd_last[i], exp_d, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    // Narrow beat size: SLVERR, and nothing is committed.
    wd[0] = 64'h0; ws[0] = 8'hFF;
    do_write(32'h0000_1000, 8'd0, 3'b010, 2'b01, 0);
    n_checks++;
    if (wr_resp !== 2'b10) $display("FAIL bad_size_bresp: got %b want %b", wr_resp, 2'b10);
    else n_pass++;
    do_read(32'h0000_1000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_data[0] !== 64'hDEADBEEFCAFEBABE) $display("FAIL bad_size_mem: got %h want deadbeefcafebabe", rd_data[0]);
    else n_pass++;
    // Early wlast on beat 1 of 4: all four beats are taken, then SLVERR.
    for (int i = 0; i < 4; i++) begin wd[i] = 64'h0; ws[i] = 8'hFF; end
    do_write(32'h0000_4000, 8'd3, 3'b011, 2'b01, 1);
    n_checks++;
    if (wr_beats != 4 || wr_resp !== 2'b10 || wr_ok !== 1'b1)
      $display("FAIL early_wlast: got beats=%0d resp=%b ok=%b want 4 10 1", wr_beats, wr_resp, wr_ok);
    else n_pass++;
    // wlast missing on the last beat.
    do_write(32'h0000_6000, 8'd1, 3'b011, 2'b01, -1);
    n_checks++;
    if (wr_beats != 2 || wr_resp !== 2'b10)
      $display("FAIL missing_wlast: got beats=%0d resp=%b want 2 10", wr_beats, wr_resp);
    else n_pass++;
    // WRAP read: SLVERR with zeroed data.
    do_read(32'h0000_1000, 8'd0, 3'b011, 2'b10, -1, 0);
    n_checks++;
    if (rd_n != 1 || rd_resp[0] !== 2'b10 || rd_data[0] !== 64'd0 || rd_last[0] !== 1'b1)
      $display("FAIL wrap_read: got beats=%0d resp=%b data=%h last=%b want 1 10 0 1",
               rd_n, rd_resp[0], rd_data[0], rd_last[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    int k;
    cyc = 0; k = 0;
    @(negedge clk);
    axi_araddr = 32'h0000_2000; axi_arlen = 8'd3; axi_arsize = 3'b011; axi_arburst = 2'b01;
    axi_arvalid = 1'b1;
    while (axi_arready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    axi_arvalid = 1'b0;
    axi_rready  = 1'b1;
    while (k < 2 && cyc < 100) begin
      if (axi_rvalid === 1'b1) k++;
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (axi_rvalid !== 1'b1 || axi_rdata !== 64'h1111111111111113)
      $display("FAIL mid_beat2: got valid=%b data=%h want 1 1111111111111113", axi_rvalid, axi_rdata);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({axi_rvalid, axi_arready, axi_rlast} !== 3'b000)
      $display("FAIL mid_async_clear: got %b want %b", {axi_rvalid, axi_arready, axi_rlast}, 3'b000);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    axi_rready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({axi_arready, axi_rvalid} !== 2'b10)
      $display("FAIL mid_release: got %b want %b", {axi_arready, axi_rvalid}, 2'b10);
    else n_pass++;
    do_read(32'h0000_1000, 8'd0, 3'b011, 2'b01, -1, 0);
    n_checks++;
    if (rd_ok !== 1'b1 || rd_n != 1 || rd_data[0] !== 64'hDEADBEEFCAFEBABE)
      $display("FAIL mid_new_read: got ok=%b beats=%0d data=%h want 1 1 deadbeefcafebabe", rd_ok, rd_n, rd_data[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_wrap_alias_fixed();
    test_strobe();
    test_backpressure();
    test_errors();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
